// File: rtl/ray_pkg.sv
// Shared types and constants for the ray-core dispatcher and its arbiter.
package ray_pkg;

  localparam int MAX_CORES = 4;
  localparam int RAY_CW    = 12;
  localparam int OP_W      = 2;

  typedef logic signed [RAY_CW-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } ray_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } disp_state_t;

  // Cyclic successor of a core id within a pool of n cores.
  function automatic logic [OP_W-1:0] wrap_inc(input logic [OP_W-1:0] v, input int n);
    return (int'(v) >= n - 1) ? '0 : v + OP_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational cyclic-priority arbiter: the first asserted request at or after
// ptr wins, reported both one-hot and as an index.
module rr_arbiter
  import ray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [OP_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [OP_W-1:0] grant_idx,
  output logic            grant_any
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0] slot;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    slot      = '0;
    for (int k = 0; k < MAX_CORES; k++) begin
      if (k < N && !grant_any) begin
        slot = SW'((int'(ptr) + k) % N);
        if (req[slot]) begin
          grant[slot] = 1'b1;
          grant_idx   = OP_W'(slot);
          grant_any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ray_core_dispatcher.sv
// Frame scheduler: launches NUM_CORES ray generators and funnels their rays,
// round-robin, through one registered output stage to the tracer.
module ray_core_dispatcher
  import ray_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int CW        = 12,
  parameter int IW        = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [12:0]               image_width,
  input  logic [12:0]               image_height,
  output logic [NUM_CORES-1:0]      core_en,
  output logic [1:0]                op_code,
  input  logic [NUM_CORES-1:0]      req_valid,
  input  logic [NUM_CORES*3*CW-1:0] req_dir,
  input  logic [NUM_CORES*IW-1:0]   req_index,
  output logic [NUM_CORES-1:0]      req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [CW-1:0]      out_dir_x,
  output logic signed [CW-1:0]      out_dir_y,
  output logic signed [CW-1:0]      out_dir_z,
  output logic [IW-1:0]             out_index,
  output logic [1:0]                out_core,
  output logic                      busy,
  output logic                      frame_done
);

  disp_state_t     state_q, state_d;
  logic [IW-1:0]   total_q, total_d;
  logic [IW-1:0]   delivered_q, delivered_d;
  logic [IW-1:0]   issued_q, issued_d;
  logic [OP_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [3*CW-1:0] out_dir_q, out_dir_d;
  logic [IW-1:0]   out_index_q, out_index_d;
  logic [OP_W-1:0] out_core_q, out_core_d;

  logic [NUM_CORES-1:0] grant;
  logic [OP_W-1:0]      grant_idx;
  logic                 grant_any;
  logic                 loadable, can_issue, fire, xfer;
  logic [3*CW-1:0]      sel_dir;
  logic [IW-1:0]        sel_index;
  logic [25:0]          frame_pixels;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign frame_pixels = 26'(image_width) * 26'(image_height);
  assign loadable     = !out_valid_q || out_ready;
  // Issued rays are capped at the frame total so nothing extra is pulled in.
  assign can_issue    = (state_q == RUN) && loadable && (issued_q < total_q);
  assign fire         = can_issue && grant_any;
  assign xfer         = out_valid_q && out_ready;
  assign req_ready    = can_issue ? grant : '0;

  always_comb begin
    sel_dir   = '0;
    sel_index = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        sel_dir   = req_dir[i*3*CW +: 3*CW];
        sel_index = req_index[i*IW +: IW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    delivered_d = delivered_q;
    issued_d    = issued_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_dir_d   = out_dir_q;
    out_index_d = out_index_q;
    out_core_d  = out_core_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LAUNCH;
          total_d     = IW'(frame_pixels);
          delivered_d = '0;
          issued_d    = '0;
        end
      end
      LAUNCH:  state_d = (total_q == '0) ? DONE : RUN;
      RUN:     if (xfer && (delivered_q + IW'(1) == total_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      out_valid_d = 1'b0;
      delivered_d = delivered_q + IW'(1);
    end
    if (fire) begin
      out_valid_d = 1'b1;
      out_dir_d   = sel_dir;
      out_index_d = sel_index;
      out_core_d  = grant_idx;
      issued_d    = issued_q + IW'(1);
      rr_ptr_d    = wrap_inc(grant_idx, NUM_CORES);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      total_q     <= '0;
      delivered_q <= '0;
      issued_q    <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_dir_q   <= '0;
      out_index_q <= '0;
      out_core_q  <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      delivered_q <= delivered_d;
      issued_q    <= issued_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_dir_q   <= out_dir_d;
      out_index_q <= out_index_d;
      out_core_q  <= out_core_d;
    end
  end

  assign core_en    = {NUM_CORES{state_q == RUN}};
  assign op_code    = 2'(NUM_CORES - 1);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign out_valid  = out_valid_q;
  assign out_dir_x  = out_dir_q[3*CW-1 -: CW];
  assign out_dir_y  = out_dir_q[2*CW-1 -: CW];
  assign out_dir_z  = out_dir_q[CW-1:0];
  assign out_index  = out_index_q;
  assign out_core   = out_core_q;

endmodule

// File: tb/tb_ray_core_dispatcher.sv
// Randomized bench for ray_core_dispatcher: a slot/queue reference model predicts
// grants, the output register and frame completion each cycle.
module tb_ray_core_dispatcher;

  localparam int N  = 4;
  localparam int CW = 12;
  localparam int IW = 32;
  localparam int RW = 3*CW + IW + 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [12:0]          image_width = '0;
  logic [12:0]          image_height = '0;
  logic [N-1:0]         core_en;
  logic [1:0]           op_code;
  logic [N-1:0]         req_valid = '0;
  logic [N*3*CW-1:0]    req_dir = '0;
  logic [N*IW-1:0]      req_index = '0;
  logic [N-1:0]         req_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [CW-1:0] out_dir_x, out_dir_y, out_dir_z;
  logic [IW-1:0]        out_index;
  logic [1:0]           out_core;
  logic                 busy;
  logic                 frame_done;

  ray_core_dispatcher #(.NUM_CORES(N), .CW(CW), .IW(IW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .image_width  (image_width),
    .image_height (image_height),
    .core_en      (core_en),
    .op_code      (op_code),
    .req_valid    (req_valid),
    .req_dir      (req_dir),
    .req_index    (req_index),
    .req_ready    (req_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_dir_x    (out_dir_x),
    .out_dir_y    (out_dir_y),
    .out_dir_z    (out_dir_z),
    .out_index    (out_index),
    .out_core     (out_core),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: each core's pending ray, the favoured core, one output slot.
  logic            pend_v[N];
  logic [3*CW-1:0] pend_dir[N];
  logic [IW-1:0]   pend_idx[N];
  int              m_ptr = 0;
  logic [RW-1:0]   slot = '0;
  bit              slot_full = 0;
  int              grants[$];

  task automatic new_ray(input int i);
    pend_dir[i] = (3*CW)'({$urandom, $urandom});
    pend_idx[i] = $urandom;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]              = pend_v[i];
      req_dir[i*3*CW +: 3*CW]   = pend_dir[i];
      req_index[i*IW +: IW]     = pend_idx[i];
    end
  endtask

  // mode: 0 random, 1 five-cycle stall, 2 sparse cores, 3 extra start mid-run
  task automatic run_frame(input int w, input int h, input int mode,
                           input int valid_pct, input int ready_pct);
    int           total;
    int           issued;
    int           delivered;
    int           cyc;
    int           g;
    bit           can;
    logic [N-1:0] mask;
    logic [N-1:0] exp_grant;
    total     = w * h;
    issued    = 0;
    delivered = 0;
    cyc       = 0;
    slot_full = 0;
    grants.delete();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = (mode != 2);
      new_ray(i);
    end

    @(negedge clk);
    drive_reqs();
    out_ready    = 1'b1;
    image_width  = 13'(w);
    image_height = 13'(h);
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    image_width  = 13'($urandom);
    image_height = 13'($urandom);
    #1;
    check_eq("launch_busy", 128'(busy), 128'(1));
    check_eq("launch_core_en", 128'(core_en), 128'(0));
    check_eq("launch_req_ready", 128'(req_ready), 128'(0));

    while (delivered < total && cyc < 400) begin
      @(negedge clk);
      cyc++;
      mask = '1;
      if (mode == 2) mask = (issued == 0) ? 4'b0100 : 4'b1010;
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && mask[i] && ($urandom_range(99) < valid_pct)) begin
          pend_v[i] = 1'b1;
          new_ray(i);
        end
      end
      drive_reqs();
      if (mode == 1) out_ready = (cyc < 2 || cyc > 6);
      else           out_ready = ($urandom_range(99) < ready_pct);
      start = (mode == 3 && cyc == 3);
      #1;

      can       = (issued < total) && (!slot_full || out_ready);
      g         = -1;
      exp_grant = '0;
      if (can) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && pend_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      if (g >= 0) exp_grant[g] = 1'b1;

      check_eq("req_ready", 128'(req_ready), 128'(exp_grant));
      check_eq("run_core_en", 128'(core_en), 128'(4'hF));
      check_eq("out_valid", 128'(out_valid), 128'(slot_full));
      if (slot_full)
        check_eq("out_ray", 128'({out_dir_x, out_dir_y, out_dir_z, out_index, out_core}), 128'(slot));
      check_eq("run_frame_done", 128'(frame_done), 128'(0));

      if (slot_full && out_ready) begin
        delivered++;
        slot_full = 0;
      end
      if (g >= 0) begin
        slot      = {pend_dir[g], pend_idx[g], 2'(g)};
        slot_full = 1;
        issued++;
        m_ptr     = (g + 1) % N;
        pend_v[g] = 1'b0;
        grants.push_back(g);
      end
    end
    start = 1'b0;
    check_eq("delivered_total", 128'(delivered), 128'(total));

    @(negedge clk);
    #1;
    check_eq("done_pulse", 128'(frame_done), 128'(1));
    check_eq("done_busy", 128'(busy), 128'(1));
    check_eq("done_out_valid", 128'(out_valid), 128'(0));
    check_eq("done_core_en", 128'(core_en), 128'(0));
    check_eq("done_req_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    #1;
    check_eq("idle_frame_done", 128'(frame_done), 128'(0));
    check_eq("idle_busy", 128'(busy), 128'(0));
    check_eq("idle_req_ready", 128'(req_ready), 128'(0));
    $display("frame %0dx%0d mode %0d: %0d rays delivered in %0d cycles", w, h, mode, delivered, cyc);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      new_ray(i);
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_core_en", 128'(core_en), 128'(0));
    check_eq("rst_op_code", 128'(op_code), 128'(N - 1));
    check_eq("rst_frame_done", 128'(frame_done), 128'(0));
    check_eq("rst_out_core", 128'(out_core), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    m_ptr   = 0;

    run_frame(4, 2, 0, 100, 100);
    check_eq("t2_grant_count", 128'(grants.size()), 128'(8));
    for (int i = 0; i < grants.size() && i < 8; i++)
      check_eq("t2_grant_order", 128'(grants[i]), 128'(i % 4));

    run_frame(3, 3, 1, 100, 100);

    run_frame(1, 3, 2, 100, 100);
    check_eq("t4_grant_count", 128'(grants.size()), 128'(3));
    if (grants.size() == 3) begin
      check_eq("t4_grant0", 128'(grants[0]), 128'(2));
      check_eq("t4_grant1", 128'(grants[1]), 128'(3));
      check_eq("t4_grant2", 128'(grants[2]), 128'(1));
    end

    run_frame(0, 5, 0, 100, 100);
    run_frame(7, 0, 0, 100, 100);
    run_frame(4, 3, 3, 80, 70);

    for (int r = 0; r < 6; r++)
      run_frame(int'($urandom_range(6, 1)), int'($urandom_range(6, 1)), 0,
                int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));

    // Abort a frame with a ray parked in the output register.
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b1;
      new_ray(i);
    end
    @(negedge clk);
    drive_reqs();
    out_ready    = 1'b0;
    image_width  = 13'd5;
    image_height = 13'd5;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("pre_abort_out_valid", 128'(out_valid), 128'(1));
    check_eq("pre_abort_core_en", 128'(core_en), 128'(4'hF));
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 128'(out_valid), 128'(0));
    check_eq("abort_core_en", 128'(core_en), 128'(0));
    check_eq("abort_busy", 128'(busy), 128'(0));
    check_eq("abort_op_code", 128'(op_code), 128'(N - 1));
    @(negedge clk);
    reset_n = 1'b1;
    m_ptr   = 0;
    slot_full = 0;

    run_frame(3, 2, 0, 90, 80);
    check_eq("post_abort_first_grant", 128'(grants.size() > 0 ? grants[0] : -1),
             128'(grants.size() > 0 ? 0 : 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
